flow_stack: RTL and testbench

//  Parametrised control-flow state unit for the pipelined SIMD processor: holds the call/return

---
 rtl/flow_pkg.sv | 31 +++
 rtl/fs_en_lane.sv | 64 ++++++
 rtl/flow_stack.sv | 203 ++++++++++++++++++++
 tb/tb_flow_stack.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// ---------------------------------------------------------------------------
// flow_pkg
//  Shared definitions for the control-flow state unit of the SIMD pipeline.
//  - fs_op_e     : 3-bit encodings of the flow operations issued by the
//                  pipeline (call/return from stage 0, enable ops from stage 2)
//  - FC_*        : fault codes reported on flow_stack.fault_code
//  - fs_fault_t  : a fault event together with its code
// ---------------------------------------------------------------------------
package flow_pkg;

   typedef enum logic [2:0] {
      FS_NOP    = 3'd0,
      FS_CALL   = 3'd1,
      FS_RET    = 3'd2,
      FS_JUMPF  = 3'd3,
      FS_ALLEN  = 3'd4,
      FS_PUSHEN = 3'd5,
      FS_POPEN  = 3'd6
   } fs_op_e;

   localparam logic [1:0] FC_CALL_OVF = 2'd0;
   localparam logic [1:0] FC_CALL_UNF = 2'd1;
   localparam logic [1:0] FC_EN_OVF   = 2'd2;
   localparam logic [1:0] FC_EN_UNF   = 2'd3;

   typedef struct packed {
      logic       hit;
      logic [1:0] code;
   } fs_fault_t;

endpackage

// File: rtl/fs_en_lane.sv
// ---------------------------------------------------------------------------
// fs_en_lane
//  Enable-mask stack of a single SIMD lane. Bit 0 is the lane's current
//  enable; higher bits hold the enables of the enclosing nesting levels.
//  The nesting depth counter and overflow/underflow detection are shared by
//  all lanes and therefore live in flow_stack, not here.
// Ports
//  clk       in  rising-edge clock
//  reset     in  synchronous, active-low reset (stack becomes all ones)
//  do_jumpf  in  conditional disable of the current level
//  do_allen  in  re-enable the current level
//  do_push   in  open a new nesting level (copy of current enable)
//  do_pop    in  close the current nesting level (refill with 1)
//  cond      in  this lane's JUMPF condition (1 = disable)
//  en        out current enable bit (bit 0 of the stack)
// ---------------------------------------------------------------------------
module fs_en_lane #(
   parameter int EDEPTH       = 32,
   parameter int NESTED_ALLEN = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic do_jumpf,
   input  logic do_allen,
   input  logic do_push,
   input  logic do_pop,
   input  logic cond,
   output logic en
);

   logic [EDEPTH-1:0] stack;
   logic [EDEPTH-1:0] stack_nxt;

   // Next-stack selection. The decoder in flow_stack guarantees at most one
   // of the strobes is active per cycle. In nested mode ALLEN restores the
   // enable of the enclosing level instead of forcing the lane on, so lanes
   // disabled outside the current block stay disabled.
   always_comb begin
      stack_nxt = stack;
      if (do_jumpf) begin
         if (cond) begin
            stack_nxt[0] = 1'b0;
         end
      end else if (do_allen) begin
         stack_nxt[0] = (NESTED_ALLEN != 0) ? stack[1] : 1'b1;
      end else if (do_push) begin
         stack_nxt = {stack[EDEPTH-2:0], stack[0]};
      end else if (do_pop) begin
         stack_nxt = {1'b1, stack[EDEPTH-1:1]};
      end
   end

   // Stack register; reset enables every level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stack <= '1;
      end else begin
         stack <= stack_nxt;
      end
   end

   assign en = stack[0];

endmodule

// File: rtl/flow_stack.sv
// ---------------------------------------------------------------------------
// flow_stack
//  Control-flow state unit of the pipelined SIMD processor: circular
//  call/return stack plus one enable-mask stack per lane, with occupancy
//  counters, overflow/underflow detection and a sticky fault report.
// Ports
//  clk         in   rising-edge clock
//  reset       in   synchronous, active-low reset (wins over any op)
//  op_valid    in   apply op this cycle
//  op          in   flow operation (flow_pkg::fs_op_e encoding)
//  call_pc     in   address pushed on CALL
//  cond        in   per-lane JUMPF condition (1 = disable lane)
//  ret_target  out  top entry + RET_OFFSET, RET_OFFSET when empty (comb.)
//  en          out  current enable bit of each lane
//  any_en      out  OR of en
//  call_depth  out  call-stack occupancy
//  en_depth    out  enable nesting level, shared by all lanes
//  fault       out  sticky fault flag
//  fault_code  out  code of the first fault since reset
// ---------------------------------------------------------------------------
module flow_stack
   import flow_pkg::*;
#(
   parameter int AW           = 16,
   parameter int CDEPTH       = 4,
   parameter int LANES        = 1,
   parameter int EDEPTH       = 32,
   parameter int RET_OFFSET   = 2,
   parameter int NESTED_ALLEN = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          op_valid,
   input  logic [2:0]                    op,
   input  logic [AW-1:0]                 call_pc,
   input  logic [LANES-1:0]              cond,
   output logic [AW-1:0]                 ret_target,
   output logic [LANES-1:0]              en,
   output logic                          any_en,
   output logic [$clog2(CDEPTH+1)-1:0]   call_depth,
   output logic [$clog2(EDEPTH+1)-1:0]   en_depth,
   output logic                          fault,
   output logic [1:0]                    fault_code
);

   localparam int CDW = $clog2(CDEPTH + 1);
   localparam int EDW = $clog2(EDEPTH + 1);
   localparam int PW  = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;

   localparam logic [CDW-1:0] CALL_FULL = CDW'(CDEPTH);
   localparam logic [EDW-1:0] EN_TOP    = EDW'(EDEPTH - 1);
   localparam logic [PW-1:0]  PTR_LAST  = PW'(CDEPTH - 1);
   localparam logic [AW-1:0]  OFFSET    = AW'(RET_OFFSET);

   logic          do_call;
   logic          do_ret;
   logic          do_jumpf;
   logic          do_allen;
   logic          do_push;
   logic          do_pop;

   logic [AW-1:0] entries [CDEPTH];
   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_inc;
   logic [PW-1:0] ptr_dec;

   logic          call_ovf;
   logic          call_unf;
   logic          en_ovf;
   logic          en_unf;
   fs_fault_t     fault_evt;

   // Op decode: exactly one strobe (or none) per cycle. Unused encodings
   // fall through to the default and act as NOP.
   always_comb begin
      do_call  = 1'b0;
      do_ret   = 1'b0;
      do_jumpf = 1'b0;
      do_allen = 1'b0;
      do_push  = 1'b0;
      do_pop   = 1'b0;
      if (op_valid) begin
         case (op)
            FS_CALL:   do_call  = 1'b1;
            FS_RET:    do_ret   = 1'b1;
            FS_JUMPF:  do_jumpf = 1'b1;
            FS_ALLEN:  do_allen = 1'b1;
            FS_PUSHEN: do_push  = 1'b1;
            FS_POPEN:  do_pop   = 1'b1;
            default:   ;
         endcase
      end
   end

   // Circular pointer arithmetic modulo CDEPTH, which need not be a power
   // of two. ptr always names the slot the next CALL writes, so the top of
   // stack sits one slot below it.
   always_comb begin
      ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
      ptr_dec = (ptr == '0) ? PTR_LAST : ptr - PW'(1);
   end

   // Return address is presented combinationally so the RET issued in
   // stage 0 can redirect fetch in the same cycle.
   always_comb begin
      if (call_depth == '0) begin
         ret_target = OFFSET;
      end else begin
         ret_target = entries[ptr_dec] + OFFSET;
      end
   end

   // Boundary detection. Only one op is active per cycle, so at most one
   // event fires and the priority order below never actually arbitrates.
   always_comb begin
      call_ovf = do_call && (call_depth == CALL_FULL);
      call_unf = do_ret  && (call_depth == '0);
      en_ovf   = do_push && (en_depth == EN_TOP);
      en_unf   = do_pop  && (en_depth == '0);
      fault_evt.hit  = call_ovf | call_unf | en_ovf | en_unf;
      fault_evt.code = FC_CALL_OVF;
      if (call_unf) begin
         fault_evt.code = FC_CALL_UNF;
      end else if (en_ovf) begin
         fault_evt.code = FC_EN_OVF;
      end else if (en_unf) begin
         fault_evt.code = FC_EN_UNF;
      end
   end

   // Call-stack storage. A CALL on a full stack lands on the oldest entry,
   // because the circular pointer has wrapped around onto it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < CDEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (do_call) begin
         entries[ptr] <= call_pc;
      end
   end

   // Call pointer and occupancy. Depth saturates at CDEPTH on overflow;
   // a RET on an empty stack leaves everything untouched.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr        <= '0;
         call_depth <= '0;
      end else if (do_call) begin
         ptr <= ptr_inc;
         if (!call_ovf) begin
            call_depth <= call_depth + CDW'(1);
         end
      end else if (do_ret && !call_unf) begin
         ptr        <= ptr_dec;
         call_depth <= call_depth - CDW'(1);
      end
   end

   // Shared enable nesting counter. The lane stacks still shift on an
   // overflowing push or underflowing pop; only the counter holds.
   always_ff @(posedge clk) begin
      if (!reset) begin
         en_depth <= '0;
      end else if (do_push && !en_ovf) begin
         en_depth <= en_depth + EDW'(1);
      end else if (do_pop && !en_unf) begin
         en_depth <= en_depth - EDW'(1);
      end
   end

   // Sticky fault: the first event since reset fixes the code, later
   // events are ignored until the next reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fault      <= 1'b0;
         fault_code <= FC_CALL_OVF;
      end else if (fault_evt.hit && !fault) begin
         fault      <= 1'b1;
         fault_code <= fault_evt.code;
      end
   end

   // One enable stack per lane, all driven by the same decoded strobes.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fs_en_lane #(
         .EDEPTH       (EDEPTH),
         .NESTED_ALLEN (NESTED_ALLEN)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .do_jumpf (do_jumpf),
         .do_allen (do_allen),
         .do_push  (do_push),
         .do_pop   (do_pop),
         .cond     (cond[g]),
         .en       (en[g])
      );
   end

   assign any_en = |en;

endmodule

// File: tb/tb_flow_stack.sv
// ---------------------------------------------------------------------------
// tb_flow_stack
//  Self-checking bench for flow_stack (LANES=4, EDEPTH=8, NESTED_ALLEN=1).
//  The driver issues one op per cycle, steps a queue/array reference model
//  and pushes the expected response into a scoreboard; an independent
//  monitor samples the DUT every cycle and compares against it.
// ---------------------------------------------------------------------------
module tb_flow_stack;
   import flow_pkg::*;

   localparam int AW           = 16;
   localparam int CDEPTH       = 4;
   localparam int LANES        = 4;
   localparam int EDEPTH       = 8;
   localparam int RET_OFFSET   = 2;
   localparam int NESTED_ALLEN = 1;
   localparam int CDW          = $clog2(CDEPTH + 1);
   localparam int EDW          = $clog2(EDEPTH + 1);

   logic                clk;
   logic                reset;
   logic                op_valid;
   logic [2:0]          op;
   logic [AW-1:0]       call_pc;
   logic [LANES-1:0]    cond;
   logic [AW-1:0]       ret_target;
   logic [LANES-1:0]    en;
   logic                any_en;
   logic [CDW-1:0]      call_depth;
   logic [EDW-1:0]      en_depth;
   logic                fault;
   logic [1:0]          fault_code;

   flow_stack #(
      .AW           (AW),
      .CDEPTH       (CDEPTH),
      .LANES        (LANES),
      .EDEPTH       (EDEPTH),
      .RET_OFFSET   (RET_OFFSET),
      .NESTED_ALLEN (NESTED_ALLEN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (op_valid),
      .op         (op),
      .call_pc    (call_pc),
      .cond       (cond),
      .ret_target (ret_target),
      .en         (en),
      .any_en     (any_en),
      .call_depth (call_depth),
      .en_depth   (en_depth),
      .fault      (fault),
      .fault_code (fault_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned ret;
      int unsigned en;
      int unsigned cdepth;
      int unsigned edepth;
      int unsigned flt;
      int unsigned code;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;
   int          n_pushed = 0;
   int          n_checked = 0;

   // Reference model: call stack as a queue (back = top), each lane stack
   // as an array with index 0 = current level.
   int unsigned call_q[$];
   bit          lane_bits [LANES][EDEPTH];
   int          m_edepth;
   bit          m_fault;
   int unsigned m_code;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelReset();
      call_q.delete();
      for (int i = 0; i < LANES; i++)
         for (int k = 0; k < EDEPTH; k++)
            lane_bits[i][k] = 1'b1;
      m_edepth = 0;
      m_fault  = 1'b0;
      m_code   = 0;
   endfunction

   function automatic void raise(input int unsigned code);
      if (!m_fault) begin
         m_fault = 1'b1;
         m_code  = code;
      end
   endfunction

   function automatic int unsigned modelRet();
      if (call_q.size() == 0) return RET_OFFSET;
      return (call_q[call_q.size()-1] + RET_OFFSET) % (1 << AW);
   endfunction

   function automatic int unsigned modelEn();
      int unsigned v = 0;
      for (int i = 0; i < LANES; i++)
         if (lane_bits[i][0]) v += (1 << i);
      return v;
   endfunction

   function automatic void modelStep(input bit rst_n, input bit vld, input logic [2:0] o,
                                     input logic [AW-1:0] pc, input logic [LANES-1:0] c);
      int unsigned tmp;
      if (!rst_n) begin
         modelReset();
         return;
      end
      if (!vld) return;
      case (o)
         FS_CALL: begin
            if (call_q.size() == CDEPTH) begin
               tmp = call_q.pop_front();
               raise(0);
            end
            call_q.push_back(int'(pc));
         end
         FS_RET: begin
            if (call_q.size() == 0) raise(1);
            else tmp = call_q.pop_back();
         end
         FS_JUMPF: begin
            for (int i = 0; i < LANES; i++)
               if (c[i]) lane_bits[i][0] = 1'b0;
         end
         FS_ALLEN: begin
            for (int i = 0; i < LANES; i++)
               lane_bits[i][0] = (NESTED_ALLEN != 0) ? lane_bits[i][1] : 1'b1;
         end
         FS_PUSHEN: begin
            for (int i = 0; i < LANES; i++) begin
               for (int k = EDEPTH - 1; k > 0; k--) lane_bits[i][k] = lane_bits[i][k-1];
            end
            if (m_edepth == EDEPTH - 1) raise(2);
            else m_edepth++;
         end
         FS_POPEN: begin
            for (int i = 0; i < LANES; i++) begin
               for (int k = 0; k < EDEPTH - 1; k++) lane_bits[i][k] = lane_bits[i][k+1];
               lane_bits[i][EDEPTH-1] = 1'b1;
            end
            if (m_edepth == 0) raise(3);
            else m_edepth--;
         end
         default: ;
      endcase
   endfunction

   // Drive one cycle of stimulus at the falling edge, step the model and
   // queue the response expected around the following rising edge.
   task automatic applyStimulus(input bit rst_n, input bit vld, input logic [2:0] o,
                                input logic [AW-1:0] pc, input logic [LANES-1:0] c);
      exp_t e;
      @(negedge clk);
      reset    = rst_n;
      op_valid = vld;
      op       = o;
      call_pc  = pc;
      cond     = c;
      e.ret    = modelRet();
      modelStep(rst_n, vld, o, pc, c);
      e.en     = modelEn();
      e.cdepth = call_q.size();
      e.edepth = m_edepth;
      e.flt    = m_fault;
      e.code   = m_code;
      sb_q.push_back(e);
      n_pushed++;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: ret_target is sampled before the edge (it belongs to the op
   // being presented), registered outputs just after it.
   initial begin
      exp_t        e;
      logic [31:0] ret_pre;
      forever begin
         @(negedge clk);
         #2;
         ret_pre = 32'(ret_target);
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checked++;
            checkOutput("sb_ret_target", ret_pre, e.ret);
            checkOutput("sb_en", 32'(en), e.en);
            checkOutput("sb_any_en", 32'(any_en), (e.en != 0) ? 1 : 0);
            checkOutput("sb_call_depth", 32'(call_depth), e.cdepth);
            checkOutput("sb_en_depth", 32'(en_depth), e.edepth);
            checkOutput("sb_fault", 32'(fault), e.flt);
            checkOutput("sb_fault_code", 32'(fault_code), e.code);
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset    = 1'b0;
      op_valid = 1'b0;
      op       = FS_NOP;
      call_pc  = '0;
      cond     = '0;
      modelReset();
      repeat (2) @(negedge clk);

      // Reset then idle
      applyStimulus(1'b0, 1'b0, FS_NOP, '0, '0);
      applyStimulus(1'b1, 1'b0, FS_NOP, '0, '0);
      settle();
      checkOutput("idle_en", 32'(en), 32'hF);
      checkOutput("idle_any_en", 32'(any_en), 1);
      checkOutput("idle_call_depth", 32'(call_depth), 0);
      checkOutput("idle_ret_target", 32'(ret_target), 2);
      checkOutput("idle_fault", 32'(fault), 0);

      // Two calls, two returns
      applyStimulus(1'b1, 1'b1, FS_CALL, 16'h0010, '0);
      applyStimulus(1'b1, 1'b1, FS_CALL, 16'h0020, '0);
      applyStimulus(1'b1, 1'b1, FS_RET, '0, '0);
      #1 checkOutput("ret1_target", 32'(ret_target), 32'h22);
      settle();
      checkOutput("ret1_depth", 32'(call_depth), 1);
      applyStimulus(1'b1, 1'b1, FS_RET, '0, '0);
      #1 checkOutput("ret2_target", 32'(ret_target), 32'h12);
      settle();
      checkOutput("ret2_depth", 32'(call_depth), 0);

      // Call-stack overflow then drain and underflow
      for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, FS_CALL, AW'(i), '0);
      settle();
      checkOutput("ovf_depth", 32'(call_depth), 4);
      checkOutput("ovf_fault", 32'(fault), 1);
      checkOutput("ovf_code", 32'(fault_code), 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, FS_RET, '0, '0);
         #1 checkOutput("drain_target", 32'(ret_target), 32'(7 - i));
      end
      applyStimulus(1'b1, 1'b1, FS_RET, '0, '0);
      #1 checkOutput("unf_target", 32'(ret_target), 2);
      settle();
      checkOutput("unf_depth", 32'(call_depth), 0);
      checkOutput("unf_code_kept", 32'(fault_code), 0);

      // Lane enables: push, jumpf, allen, pop
      applyStimulus(1'b0, 1'b0, FS_NOP, '0, '0);
      applyStimulus(1'b1, 1'b1, FS_PUSHEN, '0, '0);
      applyStimulus(1'b1, 1'b1, FS_JUMPF, '0, 4'b0101);
      settle();
      checkOutput("jumpf_en", 32'(en), 32'hA);
      applyStimulus(1'b1, 1'b1, FS_ALLEN, '0, '0);
      settle();
      checkOutput("allen_en", 32'(en), 32'hF);
      applyStimulus(1'b1, 1'b1, FS_POPEN, '0, '0);
      settle();
      checkOutput("popen_en", 32'(en), 32'hF);
      checkOutput("popen_depth", 32'(en_depth), 0);

      // Nested ALLEN restores the enclosing level
      applyStimulus(1'b1, 1'b1, FS_JUMPF, '0, 4'b0001);
      settle();
      checkOutput("nest_jumpf1", 32'(en), 32'hE);
      applyStimulus(1'b1, 1'b1, FS_PUSHEN, '0, '0);
      applyStimulus(1'b1, 1'b1, FS_JUMPF, '0, 4'b0010);
      settle();
      checkOutput("nest_jumpf2", 32'(en), 32'hC);
      applyStimulus(1'b1, 1'b1, FS_ALLEN, '0, '0);
      settle();
      checkOutput("nest_allen", 32'(en), 32'hE);

      // Enable underflow after reset, reset beating a CALL
      applyStimulus(1'b0, 1'b0, FS_NOP, '0, '0);
      applyStimulus(1'b1, 1'b1, FS_POPEN, '0, '0);
      settle();
      checkOutput("en_unf_fault", 32'(fault), 1);
      checkOutput("en_unf_code", 32'(fault_code), 3);
      checkOutput("en_unf_en", 32'(en), 32'hF);
      applyStimulus(1'b0, 1'b1, FS_CALL, 16'h0055, '0);
      settle();
      checkOutput("rst_call_depth", 32'(call_depth), 0);
      checkOutput("rst_call_fault", 32'(fault), 0);

      // Enable overflow: depth saturates at EDEPTH-1
      for (int i = 0; i < EDEPTH; i++) applyStimulus(1'b1, 1'b1, FS_PUSHEN, '0, '0);
      settle();
      checkOutput("en_ovf_depth", 32'(en_depth), EDEPTH - 1);
      checkOutput("en_ovf_code", 32'(fault_code), 2);

      // Randomised traffic against the model
      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 79) != 0), ($urandom_range(0, 9) != 0),
                       3'($urandom_range(0, 7)), AW'($urandom), LANES'($urandom));
      end

      settle();
      #2;
      checkOutput("sb_all_checked", 32'(n_checked), 32'(n_pushed));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
